// File: rtl/scores_pkg.sv
// Shared types and constants for the Scores and display path clock-domain helpers.
package scores_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        LOCKED  = 2'd2,
        STALLED = 2'd3
    } tracker_state_t;

    localparam int unsigned SYSCLK_HZ = 100_000_000;

    // Twice the nominal divided-clock period at the slowest divider limit (4999).
    localparam int unsigned DEFAULT_TIMEOUT = 20_000;

endpackage

// File: rtl/sync_edge_detect.sv
// Brings an asynchronous divided clock into sysclk and emits registered one-cycle rise/fall ticks.
// DIV_CLK_TRACK_FILTER_EN adds a third stage that rejects single-sample glitches.
module sync_edge_detect (
    input  logic sysclk,
    input  logic reset,
    input  logic slow_clk,
    output logic rise_tick,
    output logic fall_tick
);

    logic sync0;
    logic sync1;
    logic prev;

`ifdef DIV_CLK_TRACK_FILTER_EN
    logic sync2;
    logic stable;

    // prev tracks the last accepted level, so it only moves once two samples agree.
    assign stable = (sync1 == sync2);

    always_ff @(posedge sysclk) begin
        if (reset) begin
            sync0     <= 1'b0;
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            prev      <= 1'b0;
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
        end else begin
            sync0     <= slow_clk;
            sync1     <= sync0;
            sync2     <= sync1;
            if (stable) begin
                prev <= sync1;
            end
            rise_tick <= stable &  sync1 & ~prev;
            fall_tick <= stable & ~sync1 &  prev;
        end
    end
`else
    always_ff @(posedge sysclk) begin
        if (reset) begin
            sync0     <= 1'b0;
            sync1     <= 1'b0;
            prev      <= 1'b0;
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make each stage take the previous stage's old value,
            // giving a true shift chain; blocking here would collapse it into one flop.
            sync0     <= slow_clk;
            sync1     <= sync0;
            prev      <= sync1;
            rise_tick <=  sync1 & ~prev;
            fall_tick <= ~sync1 &  prev;
        end
    end
`endif

endmodule

// File: rtl/div_clk_tracker.sv
// Tracks a divided clock from the sysclk side: edge ticks, period/high-time measurement, stall flag.
// Glitch filtering in the synchroniser is enabled by DIV_CLK_TRACK_FILTER_EN.
module div_clk_tracker
    import scores_pkg::*;
#(
    parameter int unsigned CountWidth   = 32,
    parameter int unsigned TimeoutLimit = DEFAULT_TIMEOUT
) (
    input  logic                  sysclk,
    input  logic                  reset,
    input  logic                  slow_clk,
    output logic                  rise_tick,
    output logic                  fall_tick,
    output logic [CountWidth-1:0] period,
    output logic [CountWidth-1:0] high_cycles,
    output logic                  period_valid,
    output logic                  stalled
);

    localparam logic [CountWidth-1:0] TIMEOUT_CNT = CountWidth'(TimeoutLimit);
    localparam logic [CountWidth-1:0] ONE_CNT     = CountWidth'(1);

    tracker_state_t        state;
    logic [CountWidth-1:0] cnt;
    logic                  timed_out;
    logic                  measuring;

    sync_edge_detect u_sync_edge_detect (
        .sysclk    (sysclk),
        .reset     (reset),
        .slow_clk  (slow_clk),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    // cnt holds cycles since the last rise_tick, so it reads as the period when the next rise lands.
    assign timed_out = (cnt >= TIMEOUT_CNT);
    assign measuring = (state == ARMED) || (state == LOCKED);

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            period       <= '0;
            high_cycles  <= '0;
            period_valid <= 1'b0;
            stalled      <= 1'b0;
        end else begin
            if (rise_tick) begin
                cnt <= ONE_CNT;
            end else if (!timed_out) begin
                cnt <= cnt + ONE_CNT;
            end

            if (fall_tick && measuring) begin
                high_cycles <= cnt;
            end

            // A rise in the same cycle as the timeout takes priority over stalling.
            case (state)
                IDLE: begin
                    if (rise_tick) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (rise_tick) begin
                        state        <= LOCKED;
                        period       <= cnt;
                        period_valid <= 1'b1;
                    end else if (timed_out) begin
                        state        <= STALLED;
                        stalled      <= 1'b1;
                        period_valid <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (rise_tick) begin
                        period <= cnt;
                    end else if (timed_out) begin
                        state        <= STALLED;
                        stalled      <= 1'b1;
                        period_valid <= 1'b0;
                    end
                end
                STALLED: begin
                    if (rise_tick) begin
                        state   <= ARMED;
                        stalled <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_clk_tracker.sv
// Self-checking bench for div_clk_tracker: cycle-level reference model plus directed scenarios.
module tb_div_clk_tracker;

    localparam int unsigned CW   = 16;
    localparam int unsigned TL   = 50;
    localparam int          MAXE = 4096;
`ifdef DIV_CLK_TRACK_FILTER_EN
    localparam int LAT        = 3;
    localparam int GLITCH_CNT = 0;
`else
    localparam int LAT        = 2;
    localparam int GLITCH_CNT = 1;
`endif

    logic          sysclk = 1'b0;
    logic          reset;
    logic          slow_clk;
    logic          rise_tick;
    logic          fall_tick;
    logic [CW-1:0] period;
    logic [CW-1:0] high_cycles;
    logic          period_valid;
    logic          stalled;

    int compared   = 0;
    int mismatched = 0;

    div_clk_tracker #(
        .CountWidth   (CW),
        .TimeoutLimit (TL)
    ) dut (
        .sysclk       (sysclk),
        .reset        (reset),
        .slow_clk     (slow_clk),
        .rise_tick    (rise_tick),
        .fall_tick    (fall_tick),
        .period       (period),
        .high_cycles  (high_cycles),
        .period_valid (period_valid),
        .stalled      (stalled)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // n is the index of the latest sysclk edge; expectations describe the cycle after edge n.
    typedef enum {M_IDLE, M_ARMED, M_LOCKED, M_STALLED} mphase_t;

    int      n = -1;
    bit      samp [0:MAXE-1];
    bit      model_live = 1'b0;
    bit      acc;
    bit      m_rise, m_fall, m_valid, m_stalled;
    int      m_period, m_high, last_rise;
    mphase_t phase;

    initial begin
        forever begin
            @(posedge sysclk);
            n++;
            if (reset) begin
                for (int i = 0; i < 4; i++) if (n - i >= 0) samp[n - i] = 1'b0;
                acc = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
                m_period = 0; m_high = 0; m_valid = 1'b0; m_stalled = 1'b0;
                phase = M_IDLE; last_rise = n; model_live = 1'b1;
            end else begin
                samp[n] = slow_clk;
                // Measurements react to the ticks seen in the previous cycle.
                if (m_rise) begin
                    case (phase)
                        M_IDLE:    phase = M_ARMED;
                        M_ARMED:   begin m_period = n - 1 - last_rise; m_valid = 1'b1; phase = M_LOCKED; end
                        M_LOCKED:  m_period = n - 1 - last_rise;
                        M_STALLED: begin m_stalled = 1'b0; phase = M_ARMED; end
                    endcase
                    last_rise = n - 1;
                end else begin
                    if (m_fall && (phase == M_ARMED || phase == M_LOCKED))
                        m_high = (n - 1 - last_rise > TL) ? TL : n - 1 - last_rise;
                    if ((phase == M_ARMED || phase == M_LOCKED) && (n - 1 - last_rise >= TL)) begin
                        phase = M_STALLED; m_stalled = 1'b1; m_valid = 1'b0;
                    end
                end
                // A level first sampled at edge k shows up as a tick in cycle k+LAT.
                m_rise = 1'b0; m_fall = 1'b0;
                if (n >= 3) begin
`ifdef DIV_CLK_TRACK_FILTER_EN
                    if (samp[n - 2] == samp[n - 3]) begin
                        m_rise = samp[n - 2] & ~acc;
                        m_fall = ~samp[n - 2] & acc;
                        acc    = samp[n - 2];
                    end
`else
                    m_rise = samp[n - 2] & ~samp[n - 3];
                    m_fall = ~samp[n - 2] & samp[n - 3];
`endif
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int rise_seen = 0;
    int fall_seen = 0;
    int dut_last_rise = -1;
    int got_rise = -1;

    initial begin
        forever begin
            @(negedge sysclk);
            if (model_live) begin
                check("rise_tick",    rise_tick,    m_rise);
                check("fall_tick",    fall_tick,    m_fall);
                check("period",       period,       m_period);
                check("high_cycles",  high_cycles,  m_high);
                check("period_valid", period_valid, m_valid);
                check("stalled",      stalled,      m_stalled);
                if (rise_tick === 1'b1) begin
                    rise_seen++;
                    dut_last_rise = n;
                    if (got_rise < 0) got_rise = n;
                end
                if (fall_tick === 1'b1) fall_seen++;
            end
        end
    end

    initial begin
        repeat (3000) @(posedge sysclk);
        $display("FAIL watchdog: bench did not finish within 3000 cycles");
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input bit v, input int cycles);
        slow_clk = v;
        repeat (cycles) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic run_div(input int lim, input int periods);
        repeat (periods) begin
            drive(1'b1, lim + 1);
            drive(1'b0, lim + 1);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        drive(1'b0, 2);
        reset = 1'b0;
    endtask

    initial begin
        int mark_edge;
        int stall_cyc;
        int r0, f0;

        reset    = 1'b1;
        slow_clk = 1'b0;
        repeat (4) begin
            @(posedge sysclk);
            #1;
        end
        reset = 1'b0;

        // Quiet input: nothing happens, no timeout while IDLE.
        drive(1'b0, 100);
        @(negedge sysclk);
        check("idle_rises",   rise_seen,    0);
        check("idle_valid",   period_valid, 0);
        check("idle_stalled", stalled,      0);

        // Divider limit 4: 10-cycle period, 5 high.
        mark_edge = n + 1;
        got_rise  = -1;
        run_div(4, 3);
        @(negedge sysclk);
        check("rise_latency", got_rise - mark_edge, LAT);
        check("lock_period",  period,       10);
        check("lock_high",    high_cycles,  5);
        check("lock_valid",   period_valid, 1);

        // Clock stops low: stall after TL cycles without a rise.
        stall_cyc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge sysclk);
            if (stalled === 1'b1) begin
                stall_cyc = n;
                break;
            end
        end
        check("stall_delay",  stall_cyc - (dut_last_rise + 1), TL);
        check("stall_valid",  period_valid, 0);
        check("stall_period", period,       10);

        // Restart: first rise clears stalled, second restores period_valid.
        drive(1'b1, 5);
        @(negedge sysclk);
        check("restart1_stalled", stalled,      0);
        check("restart1_valid",   period_valid, 0);
        drive(1'b0, 5);
        drive(1'b1, 5);
        @(negedge sysclk);
        check("restart2_valid",  period_valid, 1);
        check("restart2_period", period,       10);
        drive(1'b0, 5);

        // Period exactly equal to the timeout: the rise wins.
        run_div(24, 4);
        @(negedge sysclk);
        check("edge_stalled", stalled,      0);
        check("edge_period",  period,       TL);
        check("edge_high",    high_cycles,  25);
        check("edge_valid",   period_valid, 1);

        // Reset lands on the edge where a rise tick would register.
        drive(1'b1, 2);
        reset = 1'b1;
        drive(1'b1, 1);
        @(negedge sysclk);
        check("rst_rise",    rise_tick,    0);
        check("rst_fall",    fall_tick,    0);
        check("rst_period",  period,       0);
        check("rst_high",    high_cycles,  0);
        check("rst_valid",   period_valid, 0);
        check("rst_stalled", stalled,      0);
        reset = 1'b0;
        drive(1'b1, 5);
        @(negedge sysclk);
        check("relock1_valid", period_valid, 0);
        drive(1'b0, 5);
        run_div(4, 2);
        @(negedge sysclk);
        check("relock2_valid",  period_valid, 1);
        check("relock2_period", period,       10);

        // Single-sample glitch.
        pulse_reset();
        drive(1'b0, 10);
        r0 = rise_seen;
        f0 = fall_seen;
        drive(1'b1, 1);
        drive(1'b0, 20);
        @(negedge sysclk);
        check("glitch_rises", rise_seen - r0, GLITCH_CNT);
        check("glitch_falls", fall_seen - f0, GLITCH_CNT);

        // DC-high after reset: one rise, then a stall.
        pulse_reset();
        r0 = rise_seen;
        drive(1'b1, 80);
        @(negedge sysclk);
        check("dc_rises",   rise_seen - r0, 1);
        check("dc_stalled", stalled,        1);
        check("dc_valid",   period_valid,   0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
